image_streamer: RTL and testbench



---
 rtl/image_streamer_if.sv | 22 ++
 rtl/image_streamer.sv | 126 ++++++++++++
 tb/tb_image_streamer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/image_streamer_if.sv
// Receiver-side pin bundle of the accelerator image-input protocol.
// The streamer is the master; the accelerator (or its model) is the slave.
interface image_streamer_if;
   logic [6:0] data_out;
   logic       frame_n;
   logic       done_in;
   logic [3:0] bcd_in;

   modport master (
      output data_out,
      output frame_n,
      input  done_in,
      input  bcd_in
   );

   modport slave (
      input  data_out,
      input  frame_n,
      output done_in,
      output bcd_in
   );
endinterface

// File: rtl/image_streamer.sv
// Frames a 14x14 binary image as 28 seven-bit chunks, then waits for
// the accelerator's complete flag and captures its BCD classification.
module image_streamer #(
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         abort,
   input  logic [195:0] image_in,
   image_streamer_if.master rx,
   output logic         busy,
   output logic         result_valid,
   output logic [3:0]   result_digit,
   output logic         result_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GAP,
      S_SEND,
      S_WAIT
   } state_e;

   localparam logic [3:0]  GAP_LAST = 4'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES);
   localparam logic [4:0]  CHUNK_LAST = 5'd27;

   state_e       state_q;
   logic [195:0] sr_q;
   logic [3:0]   gap_q;
   logic [4:0]   chunk_q;
   logic [15:0]  wait_q;
   logic [6:0]   data_q;
   logic         frame_n_q;
   logic         busy_q;
   logic         valid_q;
   logic [3:0]   digit_q;
   logic         error_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         gap_q     <= '0;
         chunk_q   <= '0;
         wait_q    <= '0;
         data_q    <= '0;
         frame_n_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         digit_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (abort) begin
            // Abort silently drops the frame; last result is kept.
            state_q   <= S_IDLE;
            data_q    <= '0;
            frame_n_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     sr_q    <= image_in;
                     gap_q   <= '0;
                     chunk_q <= '0;
                     wait_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (gap_q == GAP_LAST) begin
                     state_q   <= S_SEND;
                     frame_n_q <= 1'b1;
                     data_q    <= sr_q[6:0];
                     sr_q      <= sr_q >> 7;
                  end else begin
                     gap_q <= gap_q + 4'd1;
                  end
               end
               S_SEND: begin
                  if (chunk_q == CHUNK_LAST) begin
                     state_q <= S_WAIT;
                     data_q  <= '0;
                  end else begin
                     data_q  <= sr_q[6:0];
                     sr_q    <= sr_q >> 7;
                     chunk_q <= chunk_q + 5'd1;
                  end
               end
               S_WAIT: begin
                  wait_q <= wait_q + 16'd1;
                  // A done on the final count still counts as success.
                  if (rx.done_in) begin
                     valid_q   <= 1'b1;
                     digit_q   <= rx.bcd_in;
                     error_q   <= (rx.bcd_in > 4'd9);
                     state_q   <= S_IDLE;
                     frame_n_q <= 1'b0;
                     busy_q    <= 1'b0;
                  end else if (wait_q + 16'd1 == TO_LAST) begin
                     valid_q   <= 1'b1;
                     digit_q   <= 4'hF;
                     error_q   <= 1'b1;
                     state_q   <= S_IDLE;
                     frame_n_q <= 1'b0;
                     busy_q    <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign rx.data_out  = data_q;
   assign rx.frame_n   = frame_n_q;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result_digit = digit_q;
   assign result_error = error_q;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: table of full frames plus
// hand-written abort, reset and priority sequences.
module tb_image_streamer;

   localparam int G  = 2;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [195:0] image_in = '0;
   logic         busy;
   logic         result_valid;
   logic [3:0]   result_digit;
   logic         result_error;

   image_streamer_if rx();

   image_streamer #(
      .GAP_CYCLES(G),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .abort(abort),
      .image_in(image_in),
      .rx(rx),
      .busy(busy),
      .result_valid(result_valid),
      .result_digit(result_digit),
      .result_error(result_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [195:0] img;
      int           done_at;
      logic [3:0]   bcd;
      bit           stale;
      bit           poke;
      logic [3:0]   exp_digit;
      logic         exp_err;
      int           exp_wait;
   } vec_t;

   vec_t vecs[6];
   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] last_digit = 4'h0;
   logic       last_err = 1'b0;

   task automatic check(input string name, input logic [195:0] act,
                        input logic [195:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [195:0] pat(input int k);
      logic [195:0] p;
      p = '0;
      for (int i = 0; i < 196; i++) begin
         case (k)
            0: p[i] = (i % 3 == 0);
            1: p[i] = (i % 5 == 1) || (i % 7 == 0);
            2: p[i] = 1'b1;
            default: p[i] = (i % 2 == 1);
         endcase
      end
      return p;
   endfunction

   // Starts a frame and collects chunks 0..upto; returns at the
   // negedge where chunk upto is on the bus.
   task automatic stream(input logic [195:0] img, input int upto,
                         input bit stale, input bit poke,
                         output logic [195:0] recon, output int early);
      recon = '0;
      early = 0;
      image_in = img;
      start = 1'b1;
      if (stale) rx.done_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int g = 0; g < G; g++) begin
         if (g > 0) @(negedge clk);
         check("gap_frame_n", rx.frame_n, 0);
         if (result_valid) early++;
      end
      for (int k = 0; k <= upto; k++) begin
         @(negedge clk);
         check("send_frame_n", rx.frame_n, 1);
         recon[7*k +: 7] = rx.data_out;
         if (result_valid) early++;
         if (poke && k == 5) begin
            start = 1'b1;
            image_in = ~img;
         end
         if (poke && k == 9) begin
            start = 1'b0;
            image_in = img;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [195:0] recon;
      int early;
      int waits;
      bit got;
      stream(v.img, 27, v.stale, v.poke, recon, early);
      check("image_reassembled", recon, v.img);
      check("no_early_result", early, 0);
      @(negedge clk);
      check("wait_data_out", rx.data_out, 0);
      check("wait_frame_n", rx.frame_n, 1);
      if (v.stale) rx.done_in = 1'b0;
      waits = 0;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         if (w == v.done_at) begin
            rx.done_in = 1'b1;
            rx.bcd_in = v.bcd;
         end
         @(negedge clk);
         rx.done_in = 1'b0;
         waits = w + 1;
         if (result_valid) got = 1'b1;
      end
      check("result_seen", got, 1);
      check("wait_cycles", waits, v.exp_wait);
      check("result_digit", result_digit, v.exp_digit);
      check("result_error", result_error, v.exp_err);
      check("busy_fall", busy, 0);
      check("frame_n_fall", rx.frame_n, 0);
      check("idle_data_out", rx.data_out, 0);
      last_digit = v.exp_digit;
      last_err = v.exp_err;
      @(negedge clk);
      check("valid_one_cycle", result_valid, 0);
      check("digit_held", result_digit, v.exp_digit);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [195:0] recon;
      int early;

      vecs[0] = '{pat(0), 0, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1};
      vecs[1] = '{pat(1), 3, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 4};
      vecs[2] = '{pat(3), -1, 4'd5, 1'b0, 1'b0, 4'hF, 1'b1, TO};
      vecs[3] = '{pat(2), 2, 4'd12, 1'b0, 1'b0, 4'd12, 1'b1, 3};
      vecs[4] = '{pat(0), TO - 1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, TO};
      vecs[5] = '{pat(2), 5, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 6};

      rx.done_in = 1'b0;
      rx.bcd_in = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_data_out", rx.data_out, 0);
      check("rst_frame_n", rx.frame_n, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_digit", result_digit, 0);
      check("rst_error", result_error, 0);
      rst_n = 1'b1;
      @(negedge clk);

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_frame_n", rx.frame_n, 0);
      @(negedge clk);
      check("start_abort_still_idle", busy, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort at chunk 10.
      stream(pat(1), 10, 1'b0, 1'b0, recon, early);
      check("abort_partial_chunks", recon[76:0], vecs[1].img[76:0]);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_frame_n", rx.frame_n, 0);
      check("abort_data_out", rx.data_out, 0);
      check("abort_busy", busy, 0);
      check("abort_valid", result_valid, 0);
      check("abort_digit_kept", result_digit, last_digit);
      check("abort_error_kept", result_error, last_err);
      repeat (3) @(negedge clk);
      check("abort_no_late_valid", result_valid, 0);

      // Abort beats done in WAIT.
      stream(pat(0), 27, 1'b0, 1'b0, recon, early);
      @(negedge clk);
      abort = 1'b1;
      rx.done_in = 1'b1;
      rx.bcd_in = 4'd4;
      @(negedge clk);
      abort = 1'b0;
      rx.done_in = 1'b0;
      check("abort_wait_valid", result_valid, 0);
      check("abort_wait_digit", result_digit, last_digit);
      check("abort_wait_frame_n", rx.frame_n, 0);
      check("abort_wait_busy", busy, 0);
      run_vec(vecs[0]);

      // Asynchronous reset at chunk 20.
      stream(pat(3), 20, 1'b0, 1'b0, recon, early);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_frame_n", rx.frame_n, 0);
      check("async_rst_data_out", rx.data_out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_digit", result_digit, 0);
      check("async_rst_valid", result_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[3]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
